// File: rtl/lagtester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lagtester_pkg
// Description : Shared state encoding and timing constants for the lag tester.
// Revision    : 1.0 - initial release
// ============================================================================
package lagtester_pkg;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned c_clock_hz            = 27_000_000;
    // 300 ms worth of sensor-domain cycles
    localparam int unsigned c_timeout_cyc_default = 8_100_000;

endpackage
`default_nettype wire

// File: rtl/lag_batch_averager.sv
`default_nettype none
// ============================================================================
// Module      : lag_batch_averager
// Description : Accumulates a power-of-two batch of samples, emits the mean.
// Revision    : 1.0 - initial release
// ============================================================================
module lag_batch_averager #(
    parameter int CNT_W        = 24,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [CNT_W-1:0]        i_value,
    output logic                    o_avg_valid,
    output logic [CNT_W-1:0]        o_avg_value,
    output logic [LOG2_SAMPLES:0]   o_batch_count
);

    // Wide enough to hold 2**LOG2_SAMPLES full-scale samples without overflow
    localparam int c_acc_w = CNT_W + LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES:0] c_batch_full = (LOG2_SAMPLES + 1)'(2 ** LOG2_SAMPLES);

    logic [c_acc_w-1:0]      r_acc;
    logic [LOG2_SAMPLES:0]   r_batch;
    logic                    r_avg_valid;
    logic [CNT_W-1:0]        r_avg_value;

    logic [c_acc_w-1:0]      w_sum;
    logic [LOG2_SAMPLES:0]   w_next_batch;

    assign w_sum        = r_acc + {{LOG2_SAMPLES{1'b0}}, i_value};
    assign w_next_batch = r_batch + (LOG2_SAMPLES + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_batch     <= '0;
            r_avg_valid <= 1'b0;
            r_avg_value <= '0;
        end else begin
            r_avg_valid <= 1'b0;
            if (i_clear) begin
                r_acc   <= '0;
                r_batch <= '0;
            end else if (i_valid) begin
                if (w_next_batch == c_batch_full) begin
                    r_avg_value <= w_sum[c_acc_w-1:LOG2_SAMPLES];
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_batch     <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_batch <= w_next_batch;
                end
            end
        end
    end

    assign o_avg_valid   = r_avg_valid;
    assign o_avg_value   = r_avg_value;
    assign o_batch_count = r_batch;

endmodule
`default_nettype wire

// File: rtl/lag_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lag_measure_sequencer
// Description : Times flash-to-sensor latency per start pulse, with timeout,
//               post-config settling and batch averaging.
// Revision    : 1.0 - initial release
// ============================================================================
module lag_measure_sequencer
    import lagtester_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int TIMEOUT_CYC   = c_timeout_cyc_default,
    parameter int SETTLE_STARTS = 4,
    parameter int LOG2_SAMPLES  = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    start_pulse,
    input  logic                    sensor_trigger,
    input  logic                    config_changed,
    output logic                    armed,
    output logic                    measuring,
    output logic                    sample_valid,
    output logic [CNT_W-1:0]        sample_value,
    output logic                    timeout_pulse,
    output logic                    avg_valid,
    output logic [CNT_W-1:0]        avg_value,
    output logic [LOG2_SAMPLES:0]   batch_count
);

    localparam int                c_settle_w   = $clog2(SETTLE_STARTS + 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_STARTS - 1);
    localparam logic [CNT_W-1:0]  c_timeout    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  c_cnt_max    = '1;

    state_t                  r_state;
    logic [c_settle_w-1:0]   r_settle_cnt;
    logic [CNT_W-1:0]        r_counter;
    logic                    r_sample_valid;
    logic [CNT_W-1:0]        r_sample_value;
    logic                    r_timeout_pulse;

    logic                    w_sample_fire;

    // Same-cycle event feeds the averager so avg_valid lines up with sample_valid
    assign w_sample_fire = (r_state == MEASURE) && sensor_trigger && !config_changed;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state         <= SETTLE;
            r_settle_cnt    <= '0;
            r_counter       <= '0;
            r_sample_valid  <= 1'b0;
            r_sample_value  <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_sample_valid  <= 1'b0;
            r_timeout_pulse <= 1'b0;
            if (config_changed) begin
                r_state      <= SETTLE;
                r_settle_cnt <= '0;
                r_counter    <= '0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (start_pulse) begin
                            r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
                            if (r_settle_cnt == c_settle_last) begin
                                r_state <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (start_pulse) begin
                            r_counter <= CNT_W'(1);
                            r_state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // A sensor edge on the timeout cycle still counts as a sample
                        if (sensor_trigger) begin
                            r_sample_valid <= 1'b1;
                            r_sample_value <= r_counter;
                            r_state        <= ARMED;
                        end else if (r_counter == c_timeout) begin
                            r_timeout_pulse <= 1'b1;
                            r_state         <= ARMED;
                        end else if (r_counter != c_cnt_max) begin
                            r_counter <= r_counter + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= SETTLE;
                    end
                endcase
            end
        end
    end

    lag_batch_averager #(
        .CNT_W        (CNT_W),
        .LOG2_SAMPLES (LOG2_SAMPLES)
    ) u_batch_averager (
        .clk           (clock),
        .rst           (rst),
        .i_clear       (config_changed),
        .i_valid       (w_sample_fire),
        .i_value       (r_counter),
        .o_avg_valid   (avg_valid),
        .o_avg_value   (avg_value),
        .o_batch_count (batch_count)
    );

    assign armed         = (r_state == ARMED);
    assign measuring     = (r_state == MEASURE);
    assign sample_valid  = r_sample_valid;
    assign sample_value  = r_sample_value;
    assign timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lag_measure_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lag_measure_sequencer
// Description : Directed scoreboard bench for lag_measure_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lag_measure_sequencer;

    localparam int c_cnt_w   = 24;
    localparam int c_timeout = 4000;
    localparam int c_log2    = 4;

    logic                 clock;
    logic                 rst;
    logic                 start_pulse;
    logic                 sensor_trigger;
    logic                 config_changed;
    logic                 armed;
    logic                 measuring;
    logic                 sample_valid;
    logic [c_cnt_w-1:0]   sample_value;
    logic                 timeout_pulse;
    logic                 avg_valid;
    logic [c_cnt_w-1:0]   avg_value;
    logic [c_log2:0]      batch_count;

    typedef struct {
        int unsigned val;
        bit          with_avg;
    } exp_sample_t;

    exp_sample_t   exp_samples[$];
    int unsigned   exp_avgs[$];
    int            exp_timeouts;
    int            n_tests;
    int            n_fail;

    lag_measure_sequencer #(
        .CNT_W         (c_cnt_w),
        .TIMEOUT_CYC   (c_timeout),
        .SETTLE_STARTS (4),
        .LOG2_SAMPLES  (c_log2)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .start_pulse    (start_pulse),
        .sensor_trigger (sensor_trigger),
        .config_changed (config_changed),
        .armed          (armed),
        .measuring      (measuring),
        .sample_valid   (sample_valid),
        .sample_value   (sample_value),
        .timeout_pulse  (timeout_pulse),
        .avg_valid      (avg_valid),
        .avg_value      (avg_value),
        .batch_count    (batch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the head of its queue
    always @(negedge clock) begin
        if (sample_valid) begin
            n_tests++;
            if (exp_samples.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample: got value %0d, expected no sample", sample_value);
            end else begin
                exp_sample_t e;
                e = exp_samples.pop_front();
                if (sample_value !== c_cnt_w'(e.val) || avg_valid !== e.with_avg) begin
                    n_fail++;
                    $display("FAIL sample: got value %0d avg_valid %0b, expected value %0d avg_valid %0b",
                             sample_value, avg_valid, e.val, e.with_avg);
                end
            end
        end
        if (avg_valid) begin
            n_tests++;
            if (exp_avgs.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_avg: got value %0d, expected no average", avg_value);
            end else begin
                int unsigned ea;
                ea = exp_avgs.pop_front();
                if (avg_value !== c_cnt_w'(ea)) begin
                    n_fail++;
                    $display("FAIL avg: got %0d, expected %0d", avg_value, ea);
                end
            end
        end
        if (timeout_pulse) begin
            n_tests++;
            if (exp_timeouts == 0) begin
                n_fail++;
                $display("FAIL unexpected_timeout: got timeout_pulse 1, expected 0");
            end else begin
                exp_timeouts--;
            end
        end
    end

    // Start pulse sampled on the edge between the two negedges; returns at the negedge after it
    task automatic pulse_start();
        @(negedge clock) start_pulse = 1'b1;
        @(negedge clock) start_pulse = 1'b0;
    endtask

    // Trigger sampled k edges after the start edge, so the counter reads k
    task automatic trig_after(input int k);
        repeat (k - 1) @(negedge clock);
        sensor_trigger = 1'b1;
        @(negedge clock) sensor_trigger = 1'b0;
    endtask

    task automatic measure(input int k, input bit with_avg, input int unsigned avg);
        exp_samples.push_back('{val: k, with_avg: with_avg});
        if (with_avg) exp_avgs.push_back(avg);
        pulse_start();
        trig_after(k);
    endtask

    task automatic stray_trigger();
        @(negedge clock) sensor_trigger = 1'b1;
        @(negedge clock) sensor_trigger = 1'b0;
    endtask

    task automatic settle_sequence(input string tag);
        for (int i = 0; i < 4; i++) begin
            stray_trigger();
            check({tag, "_armed_during_settle"}, armed, 0);
            pulse_start();
        end
        check({tag, "_armed_after_settle"}, armed, 1);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        exp_timeouts   = 0;
        rst            = 1'b1;
        start_pulse    = 1'b0;
        sensor_trigger = 1'b0;
        config_changed = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_armed", armed, 0);
        check("reset_measuring", measuring, 0);
        check("reset_strobes", {sample_valid, timeout_pulse, avg_valid}, 0);
        check("reset_sample_value", sample_value, 0);
        check("reset_avg_value", avg_value, 0);
        check("reset_batch_count", batch_count, 0);
        rst = 1'b0;

        // Four settle pulses, then the fifth is measured
        settle_sequence("boot");
        measure(2700, 1'b0, 0);
        check("batch_after_first", batch_count, 1);
        check("armed_after_first", armed, 1);

        // Stray sensor in ARMED, then simultaneous start and sensor
        stray_trigger();
        @(negedge clock);
        check("armed_after_stray", armed, 1);
        exp_samples.push_back('{val: 100, with_avg: 1'b0});
        @(negedge clock) begin start_pulse = 1'b1; sensor_trigger = 1'b1; end
        @(negedge clock) begin start_pulse = 1'b0; sensor_trigger = 1'b0; end
        check("measuring_after_simul", measuring, 1);
        trig_after(100);
        check("batch_after_simul", batch_count, 2);

        // Timeout: pulse lands exactly TIMEOUT_CYC+1 cycles after start
        pulse_start();
        repeat (c_timeout - 1) @(negedge clock);
        check("no_timeout_early", timeout_pulse, 0);
        check("measuring_before_timeout", measuring, 1);
        exp_timeouts = 1;
        @(negedge clock);
        check("timeout_on_time", timeout_pulse, 1);
        @(negedge clock);
        check("armed_after_timeout", armed, 1);
        check("batch_after_timeout", batch_count, 2);

        // Sensor on the exact timeout cycle wins
        measure(c_timeout, 1'b0, 0);
        @(negedge clock);
        check("batch_after_edge_sample", batch_count, 3);

        for (int i = 0; i < 5; i++) measure(500, 1'b0, 0);
        check("batch_before_cfg", batch_count, 8);

        // Config change mid-measure, coincident with a sensor edge
        pulse_start();
        repeat (49) @(negedge clock);
        config_changed = 1'b1;
        sensor_trigger = 1'b1;
        @(negedge clock) begin config_changed = 1'b0; sensor_trigger = 1'b0; end
        check("batch_after_cfg", batch_count, 0);
        check("armed_after_cfg", armed, 0);
        check("measuring_after_cfg", measuring, 0);
        check("sample_value_held", sample_value, 500);
        settle_sequence("cfg");

        // Full batch 1000..1015: sum 16120, mean 1007
        for (int i = 0; i < 16; i++) begin
            measure(1000 + i, (i == 15), 1007);
            if (i == 14) check("batch_at_15", batch_count, 15);
        end
        @(negedge clock);
        check("batch_after_avg", batch_count, 0);
        check("avg_value_held", avg_value, 1007);

        repeat (5) @(negedge clock);
        check("missing_samples", exp_samples.size(), 0);
        check("missing_avgs", exp_avgs.size(), 0);
        check("missing_timeouts", exp_timeouts, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lag_measure_sequencer.md
Name: lag_measure_sequencer

Overview:
- Sequences one latency measurement per displayed test flash on the sensor-side `clock` domain.
- Sensor-side signals: start pulse (already crossed from the pixel domain), debounced `sensor_trigger`, and `config_changed` from configuration.
- Runs a cycle counter from flash start to sensor edge and enforces a timeout.
- Blanks measurements for a settle period after mode changes. Accumulates a power-of-two batch of samples and emits a running average for the BCD/measure path.

Parameters:
- CNT_W, 24, width of the latency cycle counter and sample outputs.
- TIMEOUT_CYC, 8100000, cycles without sensor edge before a measurement is abandoned (300 ms at 27 MHz).
- SETTLE_STARTS, 4, start pulses ignored after reset or config change.
- LOG2_SAMPLES, 4, batch size is 2**LOG2_SAMPLES (16) samples per average.

Ports:
- clock, input, 1, sensor-domain clock. One clock only.
- rst, input, 1, synchronous active-high reset.
- start_pulse, input, 1, single-cycle pulse at flash onset (crossed starttrigger).
- sensor_trigger, input, 1, single-cycle pulse at sensor edge.
- config_changed, input, 1, single-cycle pulse on mode change.
- armed, output, 1, high in ARMED state.
- measuring, output, 1, high in MEASURE state.
- sample_valid, output, 1, one-cycle strobe with sample_value.
- sample_value, output, CNT_W, latency in clock cycles.
- timeout_pulse, output, 1, one-cycle strobe on abandoned measurement.
- avg_valid, output, 1, one-cycle strobe with avg_value.
- avg_value, output, CNT_W, mean of last completed batch.
- batch_count, output, LOG2_SAMPLES+1, samples accumulated in current batch.

Behaviour:
- Reset values (rst sampled high at clock edge):
  - State is SETTLE, settle count = 0, counter = 0, accumulator = 0, batch_count = 0.
  - All strobes 0; sample_value = 0; avg_value = 0.
  - armed = 0, measuring = 0.
- SETTLE:
  - Each start_pulse increments the settle count.
  - The start_pulse that brings the count to SETTLE_STARTS moves to ARMED. That pulse is not measured.
  - sensor_trigger is ignored.
- ARMED:
  - start_pulse clears the counter to 1 and enters MEASURE on the next edge.
  - sensor_trigger alone is ignored (stray light).
  - Simultaneous start_pulse and sensor_trigger: start wins, sensor is ignored.
- MEASURE:
  - Counter increments every cycle; it saturates at 2**CNT_W-1 (not reachable when TIMEOUT_CYC < 2**CNT_W).
  - On sensor_trigger, the next cycle has sample_valid = 1 and sample_value = counter value at the trigger edge. State returns to ARMED. Latency is 1 cycle.
  - When counter == TIMEOUT_CYC with no trigger, the next cycle has timeout_pulse = 1 and state returns to ARMED. Nothing is accumulated and batch_count is unchanged.
  - sensor_trigger on the same cycle the counter reaches TIMEOUT_CYC: the sample wins and no timeout is raised.
  - start_pulse during MEASURE is ignored; the measurement continues.
- Accumulation:
  - Each valid sample adds to an accumulator of width CNT_W+LOG2_SAMPLES, with no overflow by construction. batch_count then increments.
  - When batch_count reaches 2**LOG2_SAMPLES on that add:
    - avg_value = (accumulator including this sample) >> LOG2_SAMPLES, truncated.
    - avg_valid pulses in the same cycle as sample_valid.
    - Accumulator and batch_count clear to 0.
  - avg_value holds between strobes.
- config_changed, in any state, takes priority over everything except rst:
  - Next state is SETTLE with settle count 0.
  - Counter, accumulator and batch_count clear; any in-flight measurement is discarded with no strobe.
  - avg_value and sample_value hold their last values; the downstream BCD block clears itself on config_changed.
- Strobes never assert in the cycle after rst or config_changed.

Decomposition:
- Shared package lagtester_pkg:
  - state encoding SETTLE=0, ARMED=1, MEASURE=2.
  - default TIMEOUT_CYC and clock-frequency constant.
- One natural sub-module, lag_batch_averager: accumulator, batch counter and shift divide.
  - Inputs: sample strobe and value, clear.
  - Outputs: avg strobe and value, batch_count.

Test Plan:
- Reset release, 4 start_pulses, 5th start_pulse, sensor_trigger 2700 cycles later -> no sample from the first four; sample_valid one cycle after trigger with sample_value = 2700.
- In ARMED: sensor_trigger only -> no strobe, armed stays 1. Then start_pulse and sensor_trigger in the same cycle -> measuring = 1 next cycle, no sample.
- Start with no sensor for TIMEOUT_CYC cycles -> timeout_pulse exactly once at cycle TIMEOUT_CYC+1; batch_count unchanged; armed = 1 afterwards.
- 16 samples of values 1000..1015 -> avg_valid coincident with the 16th sample_valid, avg_value = 1007, batch_count = 0 afterwards.
- config_changed mid-MEASURE after 8 accumulated samples -> no sample or timeout strobe; batch_count = 0; 4 start_pulses ignored before the next measurement.
- Sensor edge on the exact TIMEOUT_CYC cycle -> sample_valid with value TIMEOUT_CYC, no timeout_pulse.
